// File: rtl/pwm_channel_capture.sv
// pwm_channel_capture: measures the high time of one RC receiver PWM channel
// in microseconds, then validates, clamps and strobes the result. When no pulse
// is accepted for TIMEOUT_US cycles, signal_lost is raised and the output falls
// back to DEFAULT_PULSE_US.
// Optional macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample stability filter
// after the synchroniser. It rejects spikes shorter than 3 cycles and delays
// both edges equally.
module pwm_channel_capture #(
  parameter int unsigned TIME_WIDTH       = 12,
  parameter int unsigned DEFAULT_PULSE_US = 1500,
  parameter int unsigned MIN_PULSE_US     = 1000,
  parameter int unsigned MAX_PULSE_US     = 2000,
  parameter int unsigned GLITCH_US        = 500,
  parameter int unsigned REJECT_US        = 2500,
  parameter int unsigned TIMEOUT_US       = 50000
) (
  input  logic                  us_clk,
  input  logic                  resetn,
  input  logic                  pwm_in,
  output logic [TIME_WIDTH-1:0] pulse_time_us,
  output logic                  pulse_valid,
  output logic                  signal_lost
);

  localparam int unsigned CNT_W = $clog2(REJECT_US + 1);

  localparam logic [CNT_W-1:0]      GLITCH_C  = CNT_W'(GLITCH_US);
  localparam logic [CNT_W-1:0]      REJECT_C  = CNT_W'(REJECT_US);
  localparam logic [CNT_W-1:0]      MIN_C     = CNT_W'(MIN_PULSE_US);
  localparam logic [CNT_W-1:0]      MAX_C     = CNT_W'(MAX_PULSE_US);
  localparam logic [TIME_WIDTH-1:0] DEFAULT_C = TIME_WIDTH'(DEFAULT_PULSE_US);
  localparam logic [15:0]           TO_C      = 16'(TIMEOUT_US);

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEASURE} state_t;

  state_t                  state_q, state_d;
  logic                    sync1, sync2;
  logic                    line, line_d;
  logic                    rise, fall;
  logic [CNT_W-1:0]        hi_cnt_q, hi_cnt_d;
  logic                    accept;
  logic [TIME_WIDTH-1:0]   clamped;
  logic [15:0]             to_cnt_q, to_next;

  // Two-flop synchroniser. It resets to 1 so that a pulse already high at
  // reset release looks like a held-high line instead of a fresh rise.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [2:0] hist;
  logic       filt;

  // Stability filter: the level changes only after 3 equal consecutive samples.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      hist <= '1;
      filt <= 1'b1;
    end else begin
      hist <= {hist[1:0], sync2};
      if (hist == 3'b111)      filt <= 1'b1;
      else if (hist == 3'b000) filt <= 1'b0;
    end
  end

  assign line = filt;
`else
  assign line = sync2;
`endif

  // Registered copy of the conditioned line, used for edge detection.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) line_d <= 1'b1;
    else         line_d <= line;
  end

  assign rise = line & ~line_d;
  assign fall = ~line & line_d;

  // FSM state and high-time counter registers.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= WAIT_LOW;
      hi_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hi_cnt_q <= hi_cnt_d;
    end
  end

  // Next-state logic: measure the high time and flag accepted pulses.
  always_comb begin
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;
    accept   = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (!line) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          hi_cnt_d = CNT_W'(1);
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_d = WAIT_RISE;
          accept  = (hi_cnt_q >= GLITCH_C) && (hi_cnt_q <= REJECT_C);
        end else if (hi_cnt_q == REJECT_C) begin
          state_d = WAIT_LOW;
        end else begin
          hi_cnt_d = hi_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  // Clamp the measured width into the accepted output range.
  always_comb begin
    clamped = TIME_WIDTH'(hi_cnt_q);
    if (hi_cnt_q < MIN_C)      clamped = TIME_WIDTH'(MIN_C);
    else if (hi_cnt_q > MAX_C) clamped = TIME_WIDTH'(MAX_C);
  end

  // Saturating timeout increment.
  always_comb begin
    to_next = (to_cnt_q == TO_C) ? to_cnt_q : to_cnt_q + 16'd1;
  end

  // Output registers. An accept in the same cycle as expiry takes priority
  // over the timeout.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      pulse_time_us <= DEFAULT_C;
      pulse_valid   <= 1'b0;
      signal_lost   <= 1'b1;
      to_cnt_q      <= '0;
    end else if (accept) begin
      pulse_time_us <= clamped;
      pulse_valid   <= 1'b1;
      signal_lost   <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      pulse_valid <= 1'b0;
      to_cnt_q    <= to_next;
      if (to_next == TO_C) begin
        signal_lost   <= 1'b1;
        pulse_time_us <= DEFAULT_C;
      end
    end
  end

endmodule
